instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 101 ++++++++++
 tb/tb_instruction_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs I/S/B-format instruction fields into 32-bit words and tags each one
// with a sequential word address for an instruction-memory loader.
module instruction_encoder #(
    parameter int IMMSIZE    = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [IMMSIZE-1:0]    imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err_pulse,
    output logic                  err_sticky
);

    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic [31:0]           enc_word;
    logic                  enc_ok;
    logic                  fits_12;
    logic                  fits_13;
    logic                  accept;
    logic                  handshake;

    assign in_ready  = !rst && !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign cnt_next  = handshake ? addr_cnt + ADDR_WIDTH'(1) : addr_cnt;

    // Sign-extension checks: all bits above the encodable field must match.
    assign fits_12 = (&imm[IMMSIZE-1:11]) || !(|imm[IMMSIZE-1:11]);
    assign fits_13 = ((&imm[IMMSIZE-1:12]) || !(|imm[IMMSIZE-1:12])) && !imm[0];

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (fmt)
            2'd0: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_ok   = fits_12;
            end
            2'd1: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_ok   = fits_12;
            end
            2'd2: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_ok   = fits_13;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // A rejected request is swallowed here: only the error flags react to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= '0;
            addr_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= '0;
            addr_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            addr_cnt  <= cnt_next;
            err_pulse <= accept && !enc_ok;
            if (accept && !enc_ok) begin
                err_sticky <= 1'b1;
            end
            if (accept && enc_ok) begin
                out_valid <= 1'b1;
                out_instr <= enc_word;
                out_addr  <= cnt_next;
            end else if (handshake) begin
                out_valid <= 1'b0;
                out_instr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: stimulus pushes expected words into
// a scoreboard queue that a negedge monitor drains on each output handshake.
module tb_instruction_encoder;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic        err_pulse;
    logic        err_sticky;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    instruction_encoder #(.IMMSIZE(32), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds in_valid high until the request is taken; leaves in_valid asserted.
    task automatic applyStimulus(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [31:0] im);
        bit taken = 0;
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) taken = 1;
            @(posedge clk); #1;
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic checkError(input string name);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput({name, "_err_pulse"}, {31'b0, err_pulse}, 32'd1);
        checkOutput({name, "_err_sticky"}, {31'b0, err_sticky}, 32'd1);
        checkOutput({name, "_no_valid"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({name, "_pulse_drop"}, {31'b0, err_pulse}, 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got 0x%08h addr %0d expected no output", out_instr, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_instr", out_instr, e.instr);
                checkOutput("sb_addr", {30'b0, out_addr}, {30'b0, e.addr});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_addr", {30'b0, out_addr}, 32'd0);
        checkOutput("rst_err", {30'b0, err_pulse, err_sticky}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic encodings, including the B lower range limit.
        sb.push_back('{32'h00500093, 2'd0});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
        sb.push_back('{32'hFE21AE23, 2'd1});
        applyStimulus(2'd1, 7'b0100011, 3'b010, 5'd0, 5'd3, 5'd2, -32'sd4);
        sb.push_back('{32'h00208463, 2'd2});
        applyStimulus(2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8);
        sb.push_back('{32'h80001063, 2'd3});
        applyStimulus(2'd2, 7'b1100011, 3'b001, 5'd0, 5'd0, 5'd0, -32'sd4096);

        // Rejections: odd B offset, B out of range, reserved format.
        applyStimulus(2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7);
        checkError("b_odd");
        applyStimulus(2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4096);
        checkError("b_range");
        applyStimulus(2'd3, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1);
        checkError("fmt3");

        // Counter wrapped to 0 after four words; the rejections must not advance it.
        sb.push_back('{32'h00500093, 2'd0});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
        idleCycle();

        // Clear with a stalled word pending: word dropped, sticky flag cleared.
        out_ready = 1'b0;
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd7, 5'd0, 5'd0, 32'd9);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_clear_sticky", {31'b0, err_sticky}, 32'd1);
        checkOutput("pre_clear_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(negedge clk);
        checkOutput("clear_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("clear_out_instr", out_instr, 32'd0);
        checkOutput("clear_sticky", {31'b0, err_sticky}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb.push_back('{32'hFE21AE23, 2'd0});
        applyStimulus(2'd1, 7'b0100011, 3'b010, 5'd0, 5'd3, 5'd2, -32'sd4);
        idleCycle();

        // Five back-to-back words from a cleared counter.
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        sb.push_back('{32'h00000093, 2'd0});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
        sb.push_back('{32'h00100113, 2'd1});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd1);
        sb.push_back('{32'h00200193, 2'd2});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd2);
        sb.push_back('{32'h00300213, 2'd3});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd4, 5'd0, 5'd0, 32'd3);
        sb.push_back('{32'h00400293, 2'd0});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'd4);
        idleCycle();

        // Backpressure: second request waits, first word holds steady.
        out_ready = 1'b0;
        sb.push_back('{32'hFF812283, 2'd1});
        applyStimulus(2'd0, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd8);
        sb.push_back('{32'h7E628FA3, 2'd2});
        fmt = 2'd1; opcode = 7'b0100011; funct3 = 3'b000; rd = 5'd0;
        rs1 = 5'd5; rs2 = 5'd6; imm = 32'd2047;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_instr", out_instr, 32'hFF812283);
            checkOutput("bp_addr", {30'b0, out_addr}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        idleCycle();
        idleCycle();

        // Reset in the middle of a stalled transfer.
        out_ready = 1'b0;
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd8, 5'd0, 5'd0, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_instr", out_instr, 32'd0);
        checkOutput("mid_rst_addr", {30'b0, out_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb.push_back('{32'h00500093, 2'd0});
        applyStimulus(2'd0, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
        idleCycle();
        idleCycle();

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
